// File: rtl/fifo_word_packer.sv
// Packs WIDTH-bit bytes popped from a synchronous FIFO into PACK-byte words, little-endian.
// Optional out_parity output (even parity of out_data) enabled by FIFO_WORD_PACKER_PARITY_EN.
module fifo_word_packer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PACK  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    input  logic [WIDTH-1:0]             fifo_dout,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH*PACK-1:0]        out_data,
    output logic [$clog2(PACK+1)-1:0]    out_cnt
`ifdef FIFO_WORD_PACKER_PARITY_EN
    ,
    output logic                         out_parity
`endif
);

    localparam int unsigned CW = $clog2(PACK + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned DW = WIDTH * PACK;

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        HOLD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            pend;
    logic [DW-1:0]   asm_q;
    logic            out_free_c;
    logic            load_c;
    logic            last_byte_c;

    // Pop only while filling and while the outstanding byte plus held bytes leave room.
    always_comb begin
        fifo_rd_en = !rst && !fifo_empty && (state == FILL) &&
                     ((SW'(cnt) + SW'(pend)) < SW'(PACK));
    end

    always_comb begin
        out_free_c  = !out_valid || out_ready;
        load_c      = (state == HOLD) && out_free_c;
        last_byte_c = pend && ((SW'(cnt) + SW'(1)) == SW'(PACK));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Going to HOLD on the edge that captures the last byte keeps the word period at PACK+2.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (last_byte_c) begin
                    state_nxt = HOLD;
                end else if (flush && ((cnt != '0) || pend)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!pend) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_free_c) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Assembly register: the byte popped last cycle lands in lane cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= 1'b0;
            cnt   <= '0;
            asm_q <= '0;
        end else begin
            pend <= fifo_rd_en;
            if (load_c) begin
                cnt   <= '0;
                asm_q <= '0;
            end else if (pend) begin
                for (int unsigned k = 0; k < PACK; k++) begin
                    if (cnt == CW'(k)) begin
                        asm_q[k*WIDTH +: WIDTH] <= fifo_dout;
                    end
                end
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
        end else if (load_c) begin
            out_valid <= 1'b1;
            out_data  <= asm_q;
            out_cnt   <= cnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FIFO_WORD_PACKER_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_parity <= 1'b0;
        end else if (load_c) begin
            out_parity <= ^asm_q;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer (WIDTH=8, PACK=4) with a behavioural FIFO and output collector.
module tb_fifo_word_packer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned PACK  = 4;
    localparam int unsigned DW    = WIDTH * PACK;
    localparam int unsigned CW    = $clog2(PACK + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              fifo_empty = 1'b1;
    logic              fifo_rd_en;
    logic [WIDTH-1:0]  fifo_dout = '0;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_cnt;
`ifdef FIFO_WORD_PACKER_PARITY_EN
    logic              out_parity;
`endif

    logic [WIDTH-1:0]  fifo_q[$];
    logic [DW-1:0]     got_data[$];
    logic [CW-1:0]     got_cnt[$];
    logic              got_par[$];
    int                got_cyc[$];
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    int                pops = 0;
    int                empty_pops = 0;
    int                pops_base;

    fifo_word_packer #(.WIDTH(WIDTH), .PACK(PACK)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_cnt    (out_cnt)
`ifdef FIFO_WORD_PACKER_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, empty flag updated on the clock.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            if (fifo_q.size() == 0) begin
                empty_pops++;
            end else begin
                fifo_dout <= fifo_q.pop_front();
                pops++;
            end
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Output collector.
    always @(posedge clk) begin
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_cnt.push_back(out_cnt);
            got_cyc.push_back(cyc);
`ifdef FIFO_WORD_PACKER_PARITY_EN
            got_par.push_back(out_parity);
`else
            got_par.push_back(1'b0);
`endif
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic clear_got();
        got_data.delete();
        got_cnt.delete();
        got_par.delete();
        got_cyc.delete();
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 300; i++) begin
            if (got_data.size() >= n) break;
            @(negedge clk);
        end
        check("word_count", 64'(got_data.size()), 64'(n));
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic word_at(input int idx, output logic [63:0] d, output logic [63:0] c);
        d = '1;
        c = '1;
        if (idx < got_data.size()) begin
            d = 64'(got_data[idx]);
            c = 64'(got_cnt[idx]);
        end
    endtask

    logic [63:0] d;
    logic [63:0] c;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;

        // Reset holds everything idle even with data waiting in the FIFO.
        @(negedge clk);
        push(8'h11);
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_cnt", 64'(out_cnt), 64'd0);
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);

        // Full word.
        rst = 1'b0;
        out_ready = 1'b1;
        push(8'h22); push(8'h33); push(8'h44);
        wait_words(1);
        word_at(0, d, c);
        check("full_data", d, 64'h44332211);
        check("full_cnt", c, 64'd4);
        repeat (10) @(negedge clk);
        check("full_single", 64'(got_data.size()), 64'd1);

        // Partial word via flush after both pops issued.
        clear_got();
        push(8'hA1); push(8'hA2);
        for (int i = 0; i < 50; i++) begin
            if (fifo_q.size() == 0 && fifo_empty) break;
            @(negedge clk);
        end
        pulse_flush();
        wait_words(1);
        word_at(0, d, c);
        check("part_data", d, 64'h0000A2A1);
        check("part_cnt", c, 64'd2);

        // Downstream stall: two words buffered, ninth byte stays in the FIFO.
        clear_got();
        pops_base = pops;
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) push(8'(i));
        repeat (10) @(negedge clk);
        check("stall_data_early", 64'(out_data), 64'h04030201);
        repeat (10) @(negedge clk);
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data_late", 64'(out_data), 64'h04030201);
        check("stall_cnt", 64'(out_cnt), 64'd4);
        check("stall_rd_en", 64'(fifo_rd_en), 64'd0);
        check("stall_fifo_nonempty", 64'(fifo_empty), 64'd0);
        check("stall_pops", 64'(pops - pops_base), 64'd8);
        out_ready = 1'b1;
        wait_words(2);
        word_at(0, d, c);
        check("stall_word0", d, 64'h04030201);
        word_at(1, d, c);
        check("stall_word1", d, 64'h08070605);
        repeat (10) @(negedge clk);
        pulse_flush();
        wait_words(3);
        word_at(2, d, c);
        check("tail_data", d, 64'h00000009);
        check("tail_cnt", c, 64'd1);

        // Flush while idle is ignored.
        clear_got();
        repeat (5) @(negedge clk);
        pulse_flush();
        repeat (10) @(negedge clk);
        check("idle_flush_valid", 64'(out_valid), 64'd0);
        check("idle_flush_words", 64'(got_data.size()), 64'd0);

        // Flush while a full word waits in HOLD is ignored.
        out_ready = 1'b0;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        repeat (20) @(negedge clk);
        pulse_flush();
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("hold_flush_words", 64'(got_data.size()), 64'd2);
        word_at(1, d, c);
        check("hold_flush_word1", d, 64'hD4D3D2D1);
        check("hold_flush_cnt1", c, 64'd4);

        // Reset mid-word discards the partial assembly.
        clear_got();
        push(8'hE1); push(8'hE2); push(8'hE3);
        repeat (10) @(negedge clk);
        check("midrst_no_word", 64'(got_data.size()), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        wait_words(1);
        word_at(0, d, c);
        check("midrst_data", d, 64'h88776655);
        check("midrst_cnt", c, 64'd4);
        repeat (10) @(negedge clk);
        check("midrst_single", 64'(got_data.size()), 64'd1);

        // Sustained throughput: one word every PACK+2 cycles or better.
        clear_got();
        for (int i = 0; i < 12; i++) push(8'(8'h10 + i));
        wait_words(3);
        if (got_cyc.size() >= 3) begin
            check("tput_gap1", 64'(got_cyc[1] - got_cyc[0] <= 6), 64'd1);
            check("tput_gap2", 64'(got_cyc[2] - got_cyc[1] <= 6), 64'd1);
        end
        word_at(2, d, c);
        check("tput_word2", d, 64'h1B1A1918);

`ifdef FIFO_WORD_PACKER_PARITY_EN
        clear_got();
        push(8'h07);
        repeat (5) @(negedge clk);
        pulse_flush();
        wait_words(1);
        push(8'h03);
        repeat (5) @(negedge clk);
        pulse_flush();
        wait_words(2);
        word_at(0, d, c);
        check("par_data0", d, 64'h00000007);
        word_at(1, d, c);
        check("par_data1", d, 64'h00000003);
        if (got_par.size() >= 2) begin
            check("par_bit0", 64'(got_par[0]), 64'd1);
            check("par_bit1", 64'(got_par[1]), 64'd0);
        end
`endif

        check("empty_pops", 64'(empty_pops), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter WIDTH, default 8, byte width popped from the synchronous FIFO.
REQ-002 Parameter PACK, default 4, bytes per output word; legal range 2..8.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fifo_empty  input  1  FIFO empty flag.
REQ-006 fifo_rd_en  output  1  FIFO pop request.
REQ-007 fifo_dout  input  WIDTH  FIFO read data, registered, valid the cycle after a pop.
REQ-008 flush  input  1  single-cycle request to emit a partial word.
REQ-009 out_valid  output  1  output word valid.
REQ-010 out_ready  input  1  downstream accepts the word.
REQ-011 out_data  output  WIDTH*PACK  packed word.
REQ-012 out_cnt  output  $clog2(PACK+1)  number of valid bytes in out_data.

Function
REQ-013 fifo_rd_en SHALL be combinational and high only when: !fifo_empty; state FILL; rst low; and (cnt + pend) < PACK.
- cnt: bytes held in the assembly register.
- pend: 1 if a pop was issued last cycle.
REQ-014 pend SHALL be registered as the value of fifo_rd_en (read latency exactly 1 cycle).
REQ-015 When pend is 1, fifo_dout SHALL be written into assembly byte lane cnt, and cnt SHALL increment.
- Lane k occupies bits [k*WIDTH +: WIDTH].
- The first byte popped lands in lane 0 (little-endian).
REQ-016 State machine states SHALL be FILL, DRAIN and HOLD.
REQ-017 FILL -> HOLD when cnt reaches PACK.
REQ-018 FILL -> DRAIN when flush is high, and either cnt > 0 or pend is 1; no further pops are issued.
REQ-019 FILL with flush high, cnt 0 and pend 0: flush SHALL be ignored.
REQ-020 DRAIN -> HOLD once pend is 0, i.e. the outstanding byte has been captured.
REQ-021 HOLD -> FILL when the output register is free this cycle (out_valid 0, or out_ready 1). On that edge:
- The assembly word SHALL load out_data.
- cnt SHALL load out_cnt.
- out_valid SHALL be set.
- The assembly register and cnt SHALL clear.
REQ-022 Unused upper lanes of a partial word SHALL read as zero.
REQ-023 out_valid SHALL clear on out_valid && out_ready when no new word loads that same cycle.
REQ-024 out_data and out_cnt SHALL hold stable while out_valid && !out_ready.
REQ-025 A flush arriving in DRAIN or HOLD SHALL be ignored.
REQ-026 fifo_empty rising while pend is 1 SHALL NOT drop the pending byte.
REQ-027 Sustained throughput with out_ready held high and the FIFO non-empty SHALL be one word per PACK+2 cycles or better.
REQ-028 No pop SHALL ever be issued while fifo_empty is high. No byte SHALL be lost or duplicated.

Reset
REQ-029 rst high SHALL immediately force:
- out_valid 0, out_data 0, out_cnt 0;
- cnt 0, pend 0, state FILL;
- assembly register 0;
- fifo_rd_en 0.
REQ-030 rst asserted mid-word SHALL discard the partial assembly. The first pop after release restarts at lane 0.

Configuration
REQ-031 Macro FIFO_WORD_PACKER_PARITY_EN SHALL control an output out_parity (input/output 1, even parity).
- Defined: out_parity = XOR of all out_data bits; reset 0; updated with out_data.
- Undefined: port absent; no parity logic.

Verification
REQ-032 PACK=4; push 0x11,0x22,0x33,0x44; out_ready=1 -> one word, out_data=0x44332211, out_cnt=4.
REQ-033 Push 0xA1,0xA2; pulse flush after both pops issued -> out_data=0x0000A2A1, out_cnt=2; no pop while fifo_empty.
REQ-034 Push 8 bytes 0x01..0x08; out_ready=0 for 20 cycles, then 1:
- fifo_rd_en stalls after 4 bytes are assembled.
- Words 0x04030201 then 0x08070605 are delivered in order, held stable while stalled.
REQ-035 Pulse flush with cnt=0, pend=0 -> no out_valid. Pulse flush in HOLD -> ignored, single word output.
REQ-036 Assert rst after 3 bytes captured; push 0x55,0x66,0x77,0x88 -> out_data=0x88776655, out_cnt=4.
REQ-037 With FIFO_WORD_PACKER_PARITY_EN defined, word 0x00000007 -> out_parity=1; word 0x00000003 -> out_parity=0.
